// File: rtl/systolic_result_drain_if.sv
// Capture-side and writeback-side signals of the systolic result drain.
// master = array/writeback side, slave = the drain block.
interface systolic_result_drain_if #(
   parameter int N  = 10,
   parameter int DW = 16
);
   logic            start;
   logic            psum_valid;
   logic [N*DW-1:0] psum_in;
   logic            out_valid;
   logic            out_ready;
   logic [N*DW-1:0] out_row;
   logic [3:0]      out_row_idx;
   logic            out_last;
   logic            busy;
   logic            done;

   modport master (
      output start, psum_valid, psum_in, out_ready,
      input  out_valid, out_row, out_row_idx, out_last, busy, done
   );

   modport slave (
      input  start, psum_valid, psum_in, out_ready,
      output out_valid, out_row, out_row_idx, out_last, busy, done
   );
endinterface

// File: rtl/systolic_result_drain.sv
// De-skews the bottom-row wavefront into an NxN buffer, then streams rows; out_valid one cycle after the final capture,
// rows hold while out_ready=0. Optional DRAIN_RELU_EN clamps negative output elements to zero.
module systolic_result_drain #(
   parameter int N     = 10,
   parameter int DW    = 16,
   parameter int FIRST = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   systolic_result_drain_if.slave bus
);
   localparam int LAST = FIRST + 2*N - 2;
   localparam int CW   = $clog2(LAST + 2);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] c;
   logic [3:0]    p;
   logic          done_q;
   logic [DW-1:0] mat [N][N];
   logic          cap_en, last_cap, drain, hs, last_hs;

   assign cap_en   = (state == CAPTURE) && bus.psum_valid;
   assign last_cap = cap_en && (c == CW'(LAST));
   assign drain    = (state == DRAIN);
   assign hs       = drain && bus.out_ready;
   assign last_hs  = hs && (p == 4'(N-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CAPTURE;
         CAPTURE: if (last_cap)  state_nxt = DRAIN;
         DRAIN:   if (last_hs)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c      <= '0;
         p      <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= last_hs;
         if (state == IDLE && bus.start) c <= '0;
         else if (cap_en)                c <= c + 1'b1;
         if (!drain)  p <= '0;
         else if (hs) p <= last_hs ? 4'd0 : p + 4'd1;
      end
   end

   // Element (r,j) is on column j when the capture index equals FIRST + r + j.
   always_ff @(posedge clk) begin
      for (int r = 0; r < N; r++)
         for (int j = 0; j < N; j++)
            if (cap_en && c == CW'(FIRST + r + j))
               mat[r][j] <= bus.psum_in[j*DW +: DW];
   end

   always_comb begin
      bus.out_valid   = drain;
      bus.busy        = (state != IDLE);
      bus.done        = done_q;
      bus.out_row_idx = drain ? p : 4'd0;
      bus.out_last    = drain && (p == 4'(N-1));
      bus.out_row     = '0;
      if (drain)
         for (int j = 0; j < N; j++)
`ifdef DRAIN_RELU_EN
            bus.out_row[j*DW +: DW] = mat[p][j][DW-1] ? '0 : mat[p][j];
`else
            bus.out_row[j*DW +: DW] = mat[p][j];
`endif
   end
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: scenario table plus hand-written reset and element checks.
module tb_systolic_result_drain;
   localparam int N     = 10;
   localparam int DW    = 16;
   localparam int FIRST = 9;
   localparam int NSC   = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_result_drain_if #(.N(N), .DW(DW)) bus ();
   systolic_result_drain #(.N(N), .DW(DW), .FIRST(FIRST)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      int mode;      // 0: 100*c+j, 1: constant -5
      int stall;     // valid-low cycles inserted at c=12
      int rmode;     // 0: ready always 1, 1: ready pattern 1,0,0,...
      bit poke;      // pulse start during capture/drain and with the final handshake
      int drain_cyc; // expected cycles from first out_valid to final handshake inclusive
   } sc_t;

   typedef struct {
      int            r;
      int            col;
      logic [DW-1:0] v;
   } el_t;

   sc_t           sc [NSC];
   el_t           el [7];
   logic [DW-1:0] got_m [N][N];
   int            n_chk = 0;
   int            n_err = 0;

   task automatic chk(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] stim(input int mode, input int c, input int j);
      if (mode == 0) return DW'(100*c + j);
      return DW'(-5);
   endfunction

   function automatic logic [DW-1:0] exp_elem(input int mode, input int r, input int j);
      if (mode == 0) return DW'(100*(FIRST + r + j) + j);
`ifdef DRAIN_RELU_EN
      return '0;
`else
      return DW'(-5);
`endif
   endfunction

   task automatic run_capture(input string tag, input int mode, input int stall, input bit poke);
      bit early;
      early = 1'b0;
      bus.start      = 1'b1;
      bus.psum_valid = 1'b1;           // must not be captured: still IDLE
      bus.psum_in    = {N{16'h1234}};
      tick();
      bus.start = 1'b0;
      chk({tag, "_busy_after_start"}, bus.busy, 1);
      for (int c = 0; c <= FIRST + 2*N - 2; c++) begin
         if (c == 12)
            for (int s = 0; s < stall; s++) begin
               bus.psum_valid = 1'b0;
               bus.psum_in    = {N{16'h7fff}};
               tick();
               early |= bus.out_valid;
            end
         bus.psum_valid = 1'b1;
         for (int j = 0; j < N; j++) bus.psum_in[j*DW +: DW] = stim(mode, c, j);
         bus.start = poke && (c == 5);
         tick();
         if (c < FIRST + 2*N - 2) early |= bus.out_valid;
      end
      bus.psum_valid = 1'b0;
      bus.start      = 1'b0;
      chk({tag, "_no_early_valid"}, early, 0);
      chk({tag, "_valid_after_last_capture"}, bus.out_valid, 1);
   endtask

   task automatic run_drain(input string tag, input int rmode, input bit poke, input int stop_after,
                            input int exp_cyc);
      int              hs, guard;
      bit              hold, stable_ok, idx_ok, last_ok, valid_ok, done_early, rdy;
      logic [N*DW-1:0] prev_row;
      logic [3:0]      prev_idx;
      logic            prev_last;
      hs = 0; guard = 0; hold = 0;
      stable_ok = 1; idx_ok = 1; last_ok = 1; valid_ok = 1; done_early = 0;
      prev_row = '0; prev_idx = '0; prev_last = 1'b0;
      while (hs < stop_after && guard < 200) begin
         rdy = (rmode == 0) ? 1'b1 : (guard % 3 == 0);
         if (hold)
            stable_ok &= (bus.out_row === prev_row) && (bus.out_row_idx === prev_idx) &&
                         (bus.out_last === prev_last);
         valid_ok &= (bus.out_valid === 1'b1);
         done_early |= bus.done;
         bus.out_ready = rdy;
         bus.start = poke && (hs == 3 || hs == N-1);
         if (bus.out_valid && rdy) begin
            idx_ok  &= (bus.out_row_idx == 4'(hs));
            last_ok &= (bus.out_last == (hs == N-1));
            for (int j = 0; j < N; j++) got_m[hs][j] = bus.out_row[j*DW +: DW];
            hs++;
            hold = 0;
         end else begin
            hold      = bus.out_valid;
            prev_row  = bus.out_row;
            prev_idx  = bus.out_row_idx;
            prev_last = bus.out_last;
         end
         tick();
         guard++;
      end
      bus.out_ready = 1'b0;
      chk({tag, "_handshakes"}, hs, stop_after);
      chk({tag, "_hold_stable"}, stable_ok, 1);
      chk({tag, "_row_idx_seq"}, idx_ok, 1);
      chk({tag, "_last_only_row9"}, last_ok, 1);
      chk({tag, "_valid_no_drop"}, valid_ok, 1);
      chk({tag, "_no_early_done"}, done_early, 0);
      if (stop_after == N) begin
         chk({tag, "_drain_cycles"}, guard, exp_cyc);
         chk({tag, "_done_pulse"}, bus.done, 1);
         chk({tag, "_busy_low_with_done"}, bus.busy, 0);
         chk({tag, "_valid_low_after"}, bus.out_valid, 0);
         bus.start = 1'b0;
         tick();
         chk({tag, "_done_one_cycle"}, bus.done, 0);
         chk({tag, "_start_with_done_ignored"}, bus.busy, 0);
      end
      bus.start = 1'b0;
   endtask

   task automatic chk_matrix(input string tag, input int mode);
      logic [N*DW-1:0] gr, er;
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            gr[j*DW +: DW] = got_m[r][j];
            er[j*DW +: DW] = exp_elem(mode, r, j);
         end
         chk($sformatf("%s_row%0d", tag, r), gr, er);
      end
   endtask

   initial begin
      sc[0] = '{mode: 0, stall: 0, rmode: 0, poke: 1'b0, drain_cyc: 10};
      sc[1] = '{mode: 0, stall: 3, rmode: 0, poke: 1'b0, drain_cyc: 10};
      sc[2] = '{mode: 0, stall: 0, rmode: 1, poke: 1'b0, drain_cyc: 28};
      sc[3] = '{mode: 0, stall: 0, rmode: 0, poke: 1'b1, drain_cyc: 10};
      sc[4] = '{mode: 1, stall: 0, rmode: 0, poke: 1'b0, drain_cyc: 10};

      el[0] = '{r: 0, col: 0, v: 16'd900};
      el[1] = '{r: 0, col: 1, v: 16'd1001};
      el[2] = '{r: 0, col: 2, v: 16'd1102};
      el[3] = '{r: 0, col: 9, v: 16'd1809};
      el[4] = '{r: 9, col: 0, v: 16'd1800};
      el[5] = '{r: 9, col: 9, v: 16'd2709};
      el[6] = '{r: 4, col: 5, v: 16'd1805};

      bus.start = 1'b0; bus.psum_valid = 1'b0; bus.psum_in = '0; bus.out_ready = 1'b0;
      #3;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_row", bus.out_row, 0);
      chk("rst_out_row_idx", bus.out_row_idx, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_busy", bus.busy, 0);

      for (int i = 0; i < NSC; i++) begin
         run_capture($sformatf("s%0d", i), sc[i].mode, sc[i].stall, sc[i].poke);
         run_drain($sformatf("s%0d", i), sc[i].rmode, sc[i].poke, N, sc[i].drain_cyc);
         chk_matrix($sformatf("s%0d", i), sc[i].mode);
         if (i == 0)
            for (int k = 0; k < 7; k++)
               chk($sformatf("elem_%0d_%0d", el[k].r, el[k].col), got_m[el[k].r][el[k].col], el[k].v);
         tick();
      end

      // Reset after row 4 has been accepted, then a clean rerun from row 0.
      run_capture("rst", 0, 0, 1'b0);
      run_drain("rst", 0, 1'b0, 5, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", bus.out_valid, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_out_row_idx", bus.out_row_idx, 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_capture("post", 0, 0, 1'b0);
      run_drain("post", 0, 1'b0, N, 10);
      chk_matrix("post", 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
